// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: one local command becomes one AXI read or write.
// Every handshake phase is bounded by a cycle timeout so an unresponsive slave cannot stall us.
module axil_master #(
    parameter int unsigned C_DATA_W  = 32,
    parameter int unsigned C_ADDR_W  = 32,
    parameter int unsigned C_TIMEOUT = 15
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [C_ADDR_W-1:0]   cmd_addr,
    input  logic [C_DATA_W-1:0]   cmd_wdata,
    output logic                  rsp_valid,
    output logic [C_DATA_W-1:0]   rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [C_ADDR_W-1:0]   m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [C_DATA_W-1:0]   m_axi_wdata,
    output logic [C_DATA_W/8-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [C_ADDR_W-1:0]   m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [C_DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned     CntW       = $clog2(C_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLoad    = CntW'(C_TIMEOUT - 1);
    localparam logic [1:0]      RespSlvErr = 2'b10;

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [C_ADDR_W-1:0] addr_q, addr_d;
    logic [C_DATA_W-1:0] wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [C_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, phase_done, timed_out;

    assign accept = (state_q == StIdle) && cmd_valid;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign b_hs   = m_axi_bready && m_axi_bvalid;
    assign r_hs   = m_axi_rready && m_axi_rvalid;

    // A write request phase completes only once both AW and W have handshaken; a lone
    // AW or W handshake does not restart the phase timer.
    always_comb begin
        phase_done = 1'b0;
        case (state_q)
            StWrReq:  phase_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
            StWrResp: phase_done = b_hs;
            StRdReq:  phase_done = ar_hs;
            StRdResp: phase_done = r_hs;
            default:  phase_done = 1'b0;
        endcase
    end

    assign timed_out = (state_q != StIdle) && !phase_done && (cnt_q == '0);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                if (phase_done) begin
                    state_d = StWrResp;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StRdReq: begin
                if (phase_done) begin
                    state_d = StRdResp;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StWrResp, StRdResp: begin
                if (phase_done || timed_out) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake signals decode only from registers, so no AXI input reaches an AXI output.
    always_comb begin
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            StIdle:   cmd_ready = 1'b1;
            StWrReq: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
            end
            StWrResp: m_axi_bready  = 1'b1;
            StRdReq:  m_axi_arvalid = 1'b1;
            StRdResp: m_axi_rready  = 1'b1;
            default:  cmd_ready = 1'b0;
        endcase
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = '1;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_timeout  = rsp_timeout_q;

    always_comb begin
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        if (accept) begin
            cnt_d     = CntLoad;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            addr_d    = cmd_addr;
            wdata_d   = cmd_wdata;
        end else if (state_q != StIdle) begin
            if (phase_done) begin
                cnt_d = CntLoad;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CntW'(1);
            end
            if (state_q == StWrReq) begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
            end
        end

        if (timed_out) begin
            cnt_d         = '0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RespSlvErr;
            rsp_timeout_d = 1'b1;
        end else if ((state_q == StWrResp) && b_hs) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = m_axi_bresp;
            rsp_timeout_d = 1'b0;
        end else if ((state_q == StRdResp) && r_hs) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = m_axi_rdata;
            rsp_resp_d    = m_axi_rresp;
            rsp_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cnt_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: directed table, randomized transactions against a latency/response
// model, and a mid-transaction reset sequence.
module tb_axil_master;
    localparam int TO    = 15;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    always #5 clk = ~clk;

    axil_master #(.C_DATA_W(32), .C_ADDR_W(32), .C_TIMEOUT(TO)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_to;
        logic        exp_split;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs: each ready/valid rises after its partner signal has waited *_dly cycles.
    int s_aw = 0, s_w = 0, s_b = 0, s_ar = 0, s_r = 0;
    logic [1:0]  s_resp = '0;
    logic [31:0] s_rdata = '0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            bresp = s_resp; rresp = s_resp; rdata = s_rdata;
            awready = awvalid && (aw_wait >= s_aw);
            aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
            wready  = wvalid && (w_wait >= s_w);
            w_wait  = (wvalid && !wready) ? w_wait + 1 : 0;
            arready = arvalid && (ar_wait >= s_ar);
            ar_wait = (arvalid && !arready) ? ar_wait + 1 : 0;
            bvalid  = bready && (b_wait >= s_b);
            b_wait  = (bready && !bvalid) ? b_wait + 1 : 0;
            rvalid  = rready && (r_wait >= s_r);
            r_wait  = (rready && !rvalid) ? r_wait + 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Each phase lasts (delay+1) cycles and fails if that exceeds TO; one extra cycle registers
    // the response.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int req, rsp;
        req = v.write ? ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 : v.ar_dly + 1;
        rsp = v.write ? v.b_dly + 1 : v.r_dly + 1;
        if (req > TO) begin
            r.exp_lat = TO + 1;
        end else if (rsp > TO) begin
            r.exp_lat = req + TO + 1;
        end else begin
            r.exp_lat = req + rsp + 1;
        end
        r.exp_to    = (req > TO) || (rsp > TO);
        r.exp_resp  = r.exp_to ? 2'b10 : v.resp;
        r.exp_rdata = (r.exp_to || v.write) ? 32'h0 : v.rdata;
        r.exp_split = v.write && (v.w_dly < v.aw_dly) && (v.w_dly + 1 < TO);
        return r;
    endfunction

    function automatic vec_t mkv(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input int aw, input int w, input int b, input int ar,
                                 input int rd, input logic [1:0] rsp, input logic [31:0] rdat,
                                 input int lat, input logic [1:0] eresp, input logic [31:0] erd,
                                 input logic eto, input logic esplit);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = d;
        v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = rd;
        v.resp = rsp; v.rdata = rdat;
        v.exp_lat = lat; v.exp_resp = eresp; v.exp_rdata = erd; v.exp_to = eto;
        v.exp_split = esplit;
        return v;
    endfunction

    function automatic int rdly();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(13, 16));
        return int'($urandom_range(0, 3));
    endfunction

    task automatic issue(input vec_t v, input string nm);
        s_aw = v.aw_dly; s_w = v.w_dly; s_b = v.b_dly; s_ar = v.ar_dly; s_r = v.r_dly;
        s_resp = v.resp; s_rdata = v.rdata;
        @(negedge clk);
        chk({nm, " cmd_ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run(input vec_t v, input string nm);
        int lat = 0;
        bit done = 0, bad_hold = 0, split = 0;
        issue(v, nm);
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (awvalid && awaddr !== v.addr) bad_hold = 1;
            if (wvalid && (wdata !== v.wdata || wstrb !== 4'hF)) bad_hold = 1;
            if (arvalid && araddr !== v.addr) bad_hold = 1;
            if (awvalid && !wvalid) split = 1;
            if (rsp_valid) begin
                done = 1;
                chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
                chk({nm, " resp"}, 64'(rsp_resp), 64'(v.exp_resp));
                chk({nm, " rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
                chk({nm, " timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
                chk({nm, " cmd_ready_b2b"}, 64'(cmd_ready), 64'(1));
                chk({nm, " hs_idle"}, 64'({awvalid, wvalid, bready, arvalid, rready}), 64'(0));
            end
        end
        chk({nm, " rsp_seen"}, 64'(done), 64'(1));
        chk({nm, " addr_data_hold"}, 64'(bad_hold), 64'(0));
        chk({nm, " w_before_aw"}, 64'(split), 64'(v.exp_split));
        @(negedge clk);
        chk({nm, " single_pulse"}, 64'(rsp_valid), 64'(0));
    endtask

    task automatic check_reset(input string nm);
        chk({nm, " cmd_ready"}, 64'(cmd_ready), 64'(1));
        chk({nm, " ctl"}, 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}),
            64'(0));
        chk({nm, " addr"}, {awaddr, araddr}, 64'(0));
        chk({nm, " data"}, {wdata, rsp_rdata}, 64'(0));
        chk({nm, " resp"}, 64'(rsp_resp), 64'(0));
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int n;
        tbl[0] = mkv(1, 32'h08, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,
                     3, 2'b00, 32'h0, 0, 0);
        tbl[1] = mkv(0, 32'h04, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h21100922,
                     3, 2'b00, 32'h21100922, 0, 0);
        tbl[2] = mkv(1, 32'h0C, 32'h12345678, 2, 0, 0, 0, 0, 2'b00, 32'h0,
                     5, 2'b00, 32'h0, 0, 1);
        tbl[3] = mkv(0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 2'b10, 32'hCAFE0000,
                     3, 2'b10, 32'hCAFE0000, 0, 0);
        tbl[4] = mkv(0, 32'h10, 32'h0, 0, 0, 0, NEVER, 0, 2'b00, 32'h55AA55AA,
                     16, 2'b10, 32'h0, 1, 0);
        tbl[5] = mkv(1, 32'h14, 32'hA5A5A5A5, 0, 0, 14, 0, 0, 2'b01, 32'h0,
                     17, 2'b01, 32'h0, 0, 0);
        tbl[6] = mkv(1, 32'h18, 32'h5A5A5A5A, 0, 0, 15, 0, 0, 2'b00, 32'h0,
                     17, 2'b10, 32'h0, 1, 0);
        tbl[7] = mkv(0, 32'h1C, 32'h0, 0, 0, 0, 14, 3, 2'b00, 32'h0BADF00D,
                     20, 2'b00, 32'h0BADF00D, 0, 0);
        tbl[8] = mkv(1, 32'h20, 32'h11112222, NEVER, 0, 0, 0, 0, 2'b00, 32'h0,
                     16, 2'b10, 32'h0, 1, 1);
        tbl[9] = mkv(1, 32'h24, 32'h33334444, 14, 14, 0, 0, 0, 2'b11, 32'h0,
                     17, 2'b11, 32'h0, 0, 0);

        #12;
        check_reset("reset_init");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.addr  = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.aw_dly = rdly(); v.w_dly = rdly(); v.b_dly = rdly();
            v.ar_dly = rdly(); v.r_dly = rdly();
            v.resp  = 2'($urandom_range(0, 3));
            v.rdata = $urandom;
            run(model(v), $sformatf("rand%0d", i));
        end

        // Reset while the write waits for a B response that never arrives.
        v = mkv(1, 32'h40, 32'hFEEDF00D, 0, 0, NEVER, 0, 0, 2'b00, 32'h0,
                0, 2'b00, 32'h0, 0, 0);
        issue(v, "rst_mid");
        n = 0;
        while (!bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid reach_wr_resp", 64'(bready), 64'(1));
        #2 rstn = 1'b0;
        #1;
        check_reset("rst_mid async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid no_rsp", 64'(rsp_valid), 64'(0));
        end
        rstn = 1'b1;
        run(model(mkv(0, 32'h44, 32'h0, 0, 0, 0, 1, 1, 2'b00, 32'h600DCAFE,
                      0, 2'b00, 32'h0, 0, 0)), "post_rst_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_master.md
# axil_master

Single-outstanding AXI4-Lite initiator that turns one-shot register commands from local control logic into AXI4-Lite read or write transactions and returns the response. It sits between the on-chip sequencer (gait/servo control) and the AXI4-Lite register slaves of the quadruped fabric, such as the PWM/version/scratchpad register block. Every phase is guarded by a per-phase timeout, so a dead slave cannot hang the sequencer.

## Interface
Parameters:
- C_DATA_W, 32, data width of the command, response and AXI data paths.
- C_ADDR_W, 32, address width.
- C_TIMEOUT, 15, maximum number of cycles spent waiting in any one handshake phase; must be at least 1.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_ADDR_W  byte address.
- cmd_wdata  in  C_DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  C_DATA_W  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  qualifies rsp_valid; 1 means the transaction was aborted.
- m_axi_awaddr, m_axi_awvalid out; m_axi_awready in.
- m_axi_wdata, m_axi_wvalid out; m_axi_wstrb out (C_DATA_W/8, all ones); m_axi_wready in.
- m_axi_bresp[1:0], m_axi_bvalid in; m_axi_bready out.
- m_axi_araddr, m_axi_arvalid out; m_axi_arready in.
- m_axi_rdata, m_axi_rresp[1:0], m_axi_rvalid in; m_axi_rready out.

## Operation
- States:
  - IDLE.
  - WR_REQ: awvalid and wvalid issued together.
  - WR_RESP.
  - RD_REQ.
  - RD_RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr, data and direction.
  - Next state is WR_REQ or RD_REQ.
  - The timeout counter loads C_TIMEOUT-1.
- WR_REQ:
  - awvalid and wvalid each drop independently on their own handshake (valid && ready). Either order is legal, as is the same cycle.
  - When both handshakes are done, go to WR_RESP and reload the counter.
- WR_RESP:
  - bready = 1.
  - On bvalid, capture bresp and go to IDLE.
- RD_REQ:
  - arvalid = 1 until arready, then go to RD_RESP and reload the counter.
- RD_RESP:
  - rready = 1.
  - On rvalid, capture rdata and rresp, then go to IDLE.
- Timeout:
  - In any wait state with no completing handshake, the counter decrements.
  - At counter == 0 with no handshake in that cycle:
    - Drop all valids and readies.
    - Pulse rsp_valid with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
    - Go to IDLE.
  - A handshake in the same cycle as counter == 0 wins: the response is normal.
- Address and data outputs hold stable while their valid is high. Outputs change only on clock edges, so no combinational paths go from AXI inputs to AXI outputs.
- Asserting reset mid-transaction aborts immediately. No response pulse is generated.

## Timing
- Reset values:
  - cmd_ready = 1.
  - All m_axi valids and readies = 0.
  - rsp_valid = 0 and rsp_timeout = 0.
  - All address, data and resp outputs = 0.
  - State IDLE, counter 0.
- Valids rise in the cycle after command acceptance.
- rsp_valid is registered and asserts in the cycle after the final B/R handshake. cmd_ready is already 1 in that cycle, so a new command may be accepted while rsp_valid = 1 (back-to-back).
- Minimum latency with an always-ready slave and bvalid/rvalid returned one cycle after the request handshake:
  - Acceptance edge at cycle 0.
  - AW/W or AR handshake at cycle 1.
  - B or R handshake at cycle 2.
  - rsp_valid at cycle 3.
- Timeout latency: with no slave activity, rsp_valid asserts C_TIMEOUT+1 cycles after acceptance (15 for the request phase alone plus 1 for the response register).
- rsp_rdata and rsp_resp are valid only while rsp_valid = 1; they hold their value until the next response.

## Test plan
- Write, awready/wready tied high, bvalid one cycle later with bresp = 00; write 0xDEADBEEF to 0x08:
  - awaddr = 0x08, wdata = 0xDEADBEEF, wstrb = 0xF.
  - rsp_valid at cycle 3 with rsp_resp = 00 and rsp_timeout = 0.
- Read 0x04 where the slave returns 0x21100922 with rresp = 00:
  - rsp_rdata = 0x21100922, rsp_resp = 00, latency 3.
- Write with wready arriving 2 cycles before awready:
  - wvalid drops first, awvalid stays high until its handshake.
  - Exactly one rsp_valid pulse.
- Read of an unmapped address where the slave returns rresp = 10:
  - rsp_resp = 10 and rsp_timeout = 0.
- Slave never asserts arready:
  - arvalid drops after 15 cycles.
  - rsp_valid with rsp_timeout = 1, rsp_resp = 10, rsp_rdata = 0.
  - cmd_ready returns to 1.
- Reset asserted while in WR_RESP:
  - All outputs return to reset values asynchronously.
  - No rsp_valid is generated.
  - After release, a new read completes normally.
